// File: rtl/gcd_engine.sv
// gcd_engine: subtract-and-compare GCD datapath with its own control FSM.
//
// Two operands arrive one after the other on data_in. Each is taken on a
// rising edge of the level input enter. The engine then subtracts the smaller
// operand from the larger one, one step per clock, until the two are equal or
// one of them is zero. The result is held with halt = 1. A new enter edge in
// DONE starts another run without a reset.
//
// Optional feature macro: GCD_STEPCOUNT_EN. When it is defined, the steps port
// and its saturating subtraction counter are present.
//
// Parameters
//   WIDTH      operand, result and step-counter width (>= 2)
// Ports
//   clock      system clock, all state changes on posedge
//   reset      synchronous active-high reset; aborts any run in progress
//   enter      operand strobe (level), rising-edge detected internally
//   data_in    operand bus, sampled on the cycle an enter edge is seen
//   halt       1 while a valid result is held (DONE)
//   result     last computed GCD, held until the next DONE
//   state_out  0 IDLE, 1 WAIT_Y, 2 COMPUTE, 3 DONE
//   busy       1 in COMPUTE only
//   steps      subtraction count of current/last run (GCD_STEPCOUNT_EN only)
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter,
  input  logic [WIDTH-1:0] data_in,
  output logic             halt,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_out,
  output logic             busy
`ifdef GCD_STEPCOUNT_EN
  ,
  output logic [WIDTH-1:0] steps
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_Y  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             enter_d_reg;
  logic             enter_edge;

`ifdef GCD_STEPCOUNT_EN
  logic [WIDTH-1:0] steps_reg, steps_next;
`endif

  // Reset clears enter_d. If enter is still high when reset is released,
  // that counts as one fresh edge.
  assign enter_edge = enter & ~enter_d_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      result_reg  <= '0;
      enter_d_reg <= 1'b0;
`ifdef GCD_STEPCOUNT_EN
      steps_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      result_reg  <= result_next;
      enter_d_reg <= enter;
`ifdef GCD_STEPCOUNT_EN
      steps_reg   <= steps_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    result_next = result_reg;
`ifdef GCD_STEPCOUNT_EN
    steps_next  = steps_reg;
`endif
    unique case (state_reg)
      IDLE, DONE: begin
        // In DONE, result keeps the previous answer until the next DONE.
        if (enter_edge) begin
          x_next     = data_in;
          state_next = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (enter_edge) begin
          y_next     = data_in;
`ifdef GCD_STEPCOUNT_EN
          steps_next = '0;
`endif
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        // The zero test comes first so that a zero operand cannot loop forever.
        if (x_reg == '0 || y_reg == '0) begin
          result_next = x_reg | y_reg;
          state_next  = DONE;
        end else if (x_reg == y_reg) begin
          result_next = x_reg;
          state_next  = DONE;
        end else begin
          // Always subtract the smaller from the larger, so nothing underflows.
          if (x_reg > y_reg) begin
            x_next = x_reg - y_reg;
          end else begin
            y_next = y_reg - x_reg;
          end
`ifdef GCD_STEPCOUNT_EN
          if (steps_reg != '1) begin
            steps_next = steps_reg + 1'b1;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // All status outputs are decoded from registered state only.
  assign halt      = (state_reg == DONE);
  assign busy      = (state_reg == COMPUTE);
  assign state_out = state_reg;
  assign result    = result_reg;
`ifdef GCD_STEPCOUNT_EN
  assign steps     = steps_reg;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: table-driven directed bench for gcd_engine (WIDTH = 8),
// with hand-written sequences for held enter, reset during COMPUTE and
// random pairs checked against a modulo-based Euclid model.
module tb_gcd_engine;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             enter;
  logic [WIDTH-1:0] data_in;
  logic             halt;
  logic [WIDTH-1:0] result;
  logic [1:0]       state_out;
  logic             busy;
`ifdef GCD_STEPCOUNT_EN
  logic [WIDTH-1:0] steps;
`endif

  gcd_engine #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .enter     (enter),
    .data_in   (data_in),
    .halt      (halt),
    .result    (result),
    .state_out (state_out),
    .busy      (busy)
`ifdef GCD_STEPCOUNT_EN
    ,
    .steps     (steps)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int a;
    int b;
    int exp_result;
    int exp_cycles;  // clocks from the WAIT_Y capture edge to halt
    int exp_steps;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply a one-cycle enter pulse carrying the value v.
  task automatic pulse(input logic [WIDTH-1:0] v);
    data_in = v;
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
  endtask

  // Wait for halt and count the clocks that pass.
  task automatic wait_halt(output int cycles);
    cycles = 0;
    while (!halt && cycles < 400) begin
      tick();
      cycles++;
    end
    if (!halt) check("halt_timeout", {31'd0, halt}, 32'd1);
  endtask

  function automatic int gcd_model(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  vec_t vecs[11];
  int   cyc;
  int   prev_result;
  int   ra, rb;

  initial begin
    vecs[0]  = '{12,  8,   4,   3,   2};
    vecs[1]  = '{0,   7,   7,   1,   0};
    vecs[2]  = '{7,   0,   7,   1,   0};
    vecs[3]  = '{0,   0,   0,   1,   0};
    vecs[4]  = '{255, 1,   1,   255, 254};
    vecs[5]  = '{1,   255, 1,   255, 254};
    vecs[6]  = '{100, 75,  25,  4,   3};
    vecs[7]  = '{21,  14,  7,   3,   2};
    vecs[8]  = '{9,   9,   9,   1,   0};
    vecs[9]  = '{255, 254, 1,   255, 254};
    vecs[10] = '{13,  5,   1,   6,   5};

    reset   = 1'b1;
    enter   = 1'b0;
    data_in = '0;
    tick();
    tick();
    check("reset_state",  {30'd0, state_out}, 32'd0);
    check("reset_halt",   {31'd0, halt},      32'd0);
    check("reset_busy",   {31'd0, busy},      32'd0);
    check("reset_result", {24'd0, result},    32'd0);
    reset = 1'b0;
    tick();

    // Table: each run after the first starts from DONE, without a reset.
    prev_result = -1;
    for (int i = 0; i < 11; i++) begin
      pulse(vecs[i].a[WIDTH-1:0]);
      check($sformatf("v%0d_state_wait_y", i), {30'd0, state_out}, 32'd1);
      check($sformatf("v%0d_halt_drop", i), {31'd0, halt}, 32'd0);
      if (prev_result >= 0)
        check($sformatf("v%0d_result_held", i), {24'd0, result}, prev_result);
      tick();
      pulse(vecs[i].b[WIDTH-1:0]);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d_state_compute", i), {30'd0, state_out}, 32'd2);
      wait_halt(cyc);
      check($sformatf("v%0d_latency", i), cyc, vecs[i].exp_cycles);
      check($sformatf("v%0d_result", i), {24'd0, result}, vecs[i].exp_result);
      check($sformatf("v%0d_state_done", i), {30'd0, state_out}, 32'd3);
`ifdef GCD_STEPCOUNT_EN
      check($sformatf("v%0d_steps", i), {24'd0, steps}, vecs[i].exp_steps);
`endif
      $display("vec %0d: gcd(%0d,%0d) = %0d after %0d clocks", i, vecs[i].a, vecs[i].b, result, cyc);
      prev_result = vecs[i].exp_result;
      tick();
    end

    // Enter held for 5 cycles while data changes: only 12 is captured.
    enter = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data_in = (k == 0) ? 8'd12 : 8'(100 - k);
      tick();
      check($sformatf("held_state_%0d", k), {30'd0, state_out}, 32'd1);
    end
    enter = 1'b0;
    tick();
    pulse(8'd8);
    wait_halt(cyc);
    check("held_result", {24'd0, result}, 32'd4);
    $display("held enter: result %0d after %0d clocks", result, cyc);
    tick();

    // Reset 2 cycles into the COMPUTE of 100,75. Enter stays high across the
    // reset release, and that counts as one edge that captures X = 100.
    pulse(8'd100);
    tick();
    pulse(8'd75);
    tick();
    tick();
    data_in = 8'd100;
    enter   = 1'b1;
    reset   = 1'b1;
    tick();
    check("abort_state",  {30'd0, state_out}, 32'd0);
    check("abort_halt",   {31'd0, halt},      32'd0);
    check("abort_busy",   {31'd0, busy},      32'd0);
    check("abort_result", {24'd0, result},    32'd0);
    reset = 1'b0;
    tick();
    check("release_edge_state", {30'd0, state_out}, 32'd1);
    enter = 1'b0;
    tick();
    pulse(8'd75);
    wait_halt(cyc);
    check("rerun_result", {24'd0, result}, 32'd25);
    $display("after abort: gcd(100,75) = %0d after %0d clocks", result, cyc);
    tick();

    // Random nonzero pairs checked against the Euclid model.
    for (int r = 0; r < 30; r++) begin
      ra = $urandom_range(1, 255);
      rb = $urandom_range(1, 255);
      pulse(ra[WIDTH-1:0]);
      tick();
      pulse(rb[WIDTH-1:0]);
      wait_halt(cyc);
      check($sformatf("rand%0d_gcd(%0d,%0d)", r, ra, rb), {24'd0, result}, gcd_model(ra, rb));
      $display("rand %0d: gcd(%0d,%0d) = %0d after %0d clocks", r, ra, rb, result, cyc);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
